downcount_arbiter: RTL

Round-robin controller that shares one W-bit down counter between NREQ requesters. Each requester asks for a countdown of its own length. The block grants one requester at a time, loads that requester's value, and decrements to zero. It then pulses `done` to the owner and moves on to the next requester. It is the sequencing and sharing layer above the basic decrementing counter, so several clients can time intervals without each owning a counter.

---
 rtl/downcount_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/downcount_arbiter.sv
// Round-robin arbiter sharing one W-bit down counter among NREQ requesters.
// Grants one owner, loads its value, counts to zero, pulses done, moves on.
module downcount_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] load_val_i,
    input  logic              pause_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic              busy_o,
    output logic [W-1:0]      count_o
);

    localparam int PW = $clog2(NREQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [W-1:0]    count_q, count_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic            found;
    logic [PW-1:0]   winner;
    logic [PW:0]     scanSum;
    logic [PW:0]     nextPtr;
    logic            ownerReq;

    // Scan requests starting at ptr, wrapping modulo NREQ; first hit wins.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        scanSum = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanSum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scanSum >= (PW+1)'(NREQ)) begin
                scanSum = scanSum - (PW+1)'(NREQ);
            end
            if (!found && req_i[scanSum[PW-1:0]]) begin
                found  = 1'b1;
                winner = scanSum[PW-1:0];
            end
        end
        nextPtr = {1'b0, winner} + (PW+1)'(1);
        if (nextPtr == (PW+1)'(NREQ)) begin
            nextPtr = '0;
        end
    end

    assign ownerReq = |(req_i & gnt_q);

    // Priority inside COUNT: pause, then abort, then decrement / terminal count.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << winner;
                    count_d = W'(load_val_i >> (int'(winner) * W));
                    ptr_d   = nextPtr[PW-1:0];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (pause_i) begin
                    state_d = S_COUNT;
                end else if (!ownerReq) begin
                    gnt_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - W'(1);
                end else begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign busy_o  = (state_q == S_COUNT);

endmodule
